dff_serializer: RTL

DFF_SERIALIZER -- requirements
Module: dff_serializer

---
 rtl/dff_serializer.sv | 93 +++++++++
 1 files changed

// File: rtl/dff_serializer.sv
// dff_serializer: parallel-to-serial transmitter, MSB first.
// A word accepted on a rising edge appears on D starting the next cycle and
// occupies WIDTH consecutive cycles with frame=1. word_done marks the LSB cycle.
// A new word may be accepted during the LSB cycle, so back-to-back words
// stream with no gap. D, frame and word_done come straight from flops so the
// downstream capture stage sees clean, glitch-free levels.
module dff_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             D,
  output logic             frame,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg,   cnt_next;
  logic             d_reg,     d_next;
  logic             frame_reg, frame_next;
  logic             wd_reg,    wd_next;
  logic             accept;

  // Ready while idle or while the last bit of the current word is on the line;
  // held low while reset is asserted so nothing can be accepted during reset.
  assign load_ready = reset && ((state_reg == IDLE) || (cnt_reg == '0));
  assign accept     = load_valid && load_ready;

  // Next-state and next-output decode; outputs default to the idle (all-zero) line.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    d_next     = 1'b0;
    frame_next = 1'b0;
    wd_next    = 1'b0;
    if (accept) begin
      // New word: MSB goes out next cycle; cnt counts the remaining bits.
      state_next = SHIFT;
      shreg_next = din;
      cnt_next   = CW'(WIDTH - 1);
      d_next     = din[WIDTH-1];
      frame_next = 1'b1;
    end else if (state_reg == SHIFT) begin
      if (cnt_reg != '0) begin
        // Shift left with zero fill; the bit below the MSB becomes the new MSB.
        shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        cnt_next   = cnt_reg - 1'b1;
        d_next     = shreg_reg[WIDTH-2];
        frame_next = 1'b1;
        wd_next    = (cnt_reg == CW'(1));
      end else begin
        // LSB cycle ended without a follow-on word: return to an idle line.
        state_next = IDLE;
      end
    end
  end

  // State, datapath and output registers; reset aborts any word in flight at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      d_reg     <= 1'b0;
      frame_reg <= 1'b0;
      wd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      frame_reg <= frame_next;
      wd_reg    <= wd_next;
    end
  end

  assign D         = d_reg;
  assign frame     = frame_reg;
  assign word_done = wd_reg;

endmodule
